// File: rtl/spike_output_buffer.sv
// Ping-pong capture buffer for neuron-core spike vectors, read back by the host
// over Wishbone as 32-bit words; the host frees each bank by writing its release word.
module spike_output_buffer #(
    parameter int          NUM_NEURONS = 256,
    parameter logic [31:0] OMEM_BASE_0 = 32'h80040000,
    parameter logic [31:0] OMEM_BASE_1 = 32'h80050000,
    parameter int          CNT_WIDTH   = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic [NUM_NEURONS-1:0] spike_neuron_i,
    input  logic                   spike_valid_i,
    output logic [1:0]             bank_full_o,
    output logic                   overflow_o
);
    localparam int          WORDS    = NUM_NEURONS / 32;
    localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] REL_IDX  = 30'(WORDS);
    localparam logic [29:0] STAT_IDX = 30'(WORDS + 1);

    logic [1:0][WORDS-1:0][31:0] bank;
    logic [1:0]                  full;
    logic                        wr_bank;
    logic                        overflow;
    logic [CNT_WIDTH-1:0]        cap_cnt;

    logic [31:0] off0, off1;
    logic [29:0] idx0, idx1;
    logic        sel0, sel1, hit, wr_hit;
    logic [1:0]  rel, full_rel;
    logic        w1c, cap_ok, cap_drop;
    logic [7:0]  cnt8;
    logic [31:0] status, rdata;

    // Word index relative to each base; addresses below a base wrap high and miss.
    assign off0 = wbs_adr_i - OMEM_BASE_0;
    assign off1 = wbs_adr_i - OMEM_BASE_1;
    assign idx0 = off0[31:2];
    assign idx1 = off1[31:2];
    assign sel0 = (idx0 <= STAT_IDX);
    assign sel1 = (idx1 <= REL_IDX);

    assign hit    = wbs_cyc_i & wbs_stb_i & (sel0 | sel1) & ~wbs_ack_o;
    assign wr_hit = hit & wbs_we_i;

    assign rel[0] = wr_hit & sel0 & (idx0 == REL_IDX);
    assign rel[1] = wr_hit & ~sel0 & sel1 & (idx1 == REL_IDX);
    assign w1c    = wr_hit & sel0 & (idx0 == STAT_IDX) & wbs_sel_i[0] & wbs_dat_i[3];

    // Release is applied before the capture decision so a same-cycle capture succeeds.
    assign full_rel = full & ~rel;
    assign cap_ok   = spike_valid_i & ~full_rel[wr_bank];
    assign cap_drop = spike_valid_i & full_rel[wr_bank];

    assign cnt8 = 8'(cap_cnt);

    always_comb begin
        status       = '0;
        status[0]    = full[0];
        status[1]    = full[1];
        status[2]    = wr_bank;
        status[3]    = overflow;
        status[15:8] = cnt8;
    end

    always_comb begin
        rdata = '0;
        if (sel0) begin
            if (idx0 < REL_IDX)
                rdata = bank[0][idx0[IW-1:0]];
            else if (idx0 == STAT_IDX)
                rdata = status;
        end else if (sel1 && idx1 < REL_IDX) begin
            rdata = bank[1][idx1[IW-1:0]];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            bank      <= '0;
            full      <= '0;
            wr_bank   <= 1'b0;
            overflow  <= 1'b0;
            cap_cnt   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rdata : '0;
            full      <= full_rel;
            if (cap_ok) begin
                bank[wr_bank] <= spike_neuron_i;
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                cap_cnt       <= cap_cnt + CNT_WIDTH'(1);
            end
            // A dropping capture wins over a same-cycle clear.
            overflow <= (overflow & ~w1c) | cap_drop;
        end
    end

    assign bank_full_o = full;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_spike_output_buffer.sv
// Randomized bench for spike_output_buffer against a word-array model of the two banks.
module tb_spike_output_buffer;
    localparam int          NN = 256;
    localparam logic [31:0] B0 = 32'h80040000;
    localparam logic [31:0] B1 = 32'h80050000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   adr = '0, wdat = '0;
    logic          ack;
    logic [31:0]   rdat;
    logic [NN-1:0] spike = '0;
    logic          valid = 1'b0;
    logic [1:0]    full_o;
    logic          ovf_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mbank [2][8];
    logic [1:0]  mfull;
    logic        mwr, movf;
    logic [7:0]  mcnt;

    spike_output_buffer dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .spike_neuron_i(spike), .spike_valid_i(valid),
        .bank_full_o(full_o), .overflow_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) mbank[k][i] = '0;
        mfull = '0; mwr = 1'b0; movf = 1'b0; mcnt = '0;
    endtask

    function automatic logic [31:0] mstatus();
        return {16'h0, mcnt, 4'h0, movf, mwr, mfull[1], mfull[0]};
    endfunction

    // 0 = unmapped, 1 = bank word, 2 = release, 3 = status
    function automatic int decode(input logic [31:0] a_in, output int bk, output int w);
        logic [31:0] a;
        logic [31:0] base;
        a = {a_in[31:2], 2'b00};
        bk = 0; w = 0;
        for (int k = 0; k < 2; k++) begin
            base = (k == 0) ? B0 : B1;
            if (a >= base && a < base + 32) begin
                bk = k; w = int'((a - base) >> 2); return 1;
            end
            if (a == base + 32) begin bk = k; return 2; end
        end
        if (a == B0 + 36) return 3;
        return 0;
    endfunction

    function automatic logic [NN-1:0] rand_vec();
        logic [NN-1:0] v;
        for (int i = 0; i < NN / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One bus access and/or capture issued on the same cycle, then checked.
    task automatic op(input bit bus, input logic [31:0] a, input logic w_en, input logic [31:0] wd,
                      input logic [3:0] s, input bit cap, input logic [NN-1:0] vec, input string tag);
        int k, bk, wi;
        logic [31:0] exp_rd;
        k = bus ? decode(a, bk, wi) : 0;
        exp_rd = '0;
        if (k == 1 && !w_en) exp_rd = mbank[bk][wi];
        if (k == 3 && !w_en) exp_rd = mstatus();
        @(negedge clk);
        cyc = bus; stb = bus; we = w_en; adr = a; wdat = wd; sel = s;
        valid = cap; spike = vec;
        @(negedge clk);
        valid = 1'b0;
        if (k == 2 && w_en) mfull[bk] = 1'b0;
        if (k == 3 && w_en && s[0] && wd[3]) movf = 1'b0;
        if (cap) begin
            if (mfull[mwr]) movf = 1'b1;
            else begin
                for (int i = 0; i < 8; i++) mbank[mwr][i] = vec[32*i +: 32];
                mfull[mwr] = 1'b1; mwr = ~mwr; mcnt = mcnt + 8'd1;
            end
        end
        chk({tag, " ack"}, 32'(ack), 32'(k != 0));
        chk({tag, " rdata"}, rdat, exp_rd);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, " ack_drop"}, {31'h0, ack}, 32'h0);
        chk({tag, " rdata_drop"}, rdat, 32'h0);
        chk({tag, " full"}, {30'h0, full_o}, {30'h0, mfull});
        chk({tag, " ovf"}, {31'h0, ovf_o}, {31'h0, movf});
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        op(1'b1, a, 1'b0, 32'h0, 4'hF, 1'b0, '0, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        op(1'b1, a, 1'b1, d, 4'hF, 1'b0, '0, tag);
    endtask

    task automatic cap_only(input logic [NN-1:0] v, input string tag);
        op(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, v, tag);
    endtask

    initial begin
        logic [NN-1:0] a5;
        int acks, bad_dat, back2back;
        logic prev_ack;
        model_reset();
        for (int i = 0; i < NN / 32; i++) a5[32*i +: 32] = 32'hA5A5A5A5;

        repeat (3) @(negedge clk);
        chk("rst ack", {31'h0, ack}, 32'h0);
        chk("rst dat", rdat, 32'h0);
        chk("rst full", {30'h0, full_o}, 32'h0);
        rst_n = 1'b1;
        rd(B0 + 32'h24, "status_after_reset");

        cap_only(a5, "cap_a5");
        rd(B0, "a5_w0");
        rd(B0 + 32'h1C, "a5_w7");
        rd(B0 + 32'h24, "status_one_cap");

        cap_only(rand_vec(), "cap2");
        cap_only(rand_vec(), "cap3_drop");
        rd(B0, "bank0_kept");
        rd(B0 + 32'h24, "status_ovf");
        wr(B0 + 32'h24, 32'h8, "w1c_ovf");

        // Release bank 0 while capturing into it: no overflow, new data lands.
        op(1'b1, B0 + 32'h20, 1'b1, 32'h0, 4'hF, 1'b1, NN'(1), "rel_and_cap");
        rd(B0, "relcap_w0");
        rd(B0 + 32'h24, "relcap_status");

        // Unmapped address held for ten cycles.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h80060000;
        acks = 0; bad_dat = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
            if (rdat != 0) bad_dat++;
        end
        chk("unmapped acks", 32'(acks), 32'h0);
        chk("unmapped dat", 32'(bad_dat), 32'h0);

        // Mapped read held: acks every other cycle with the right data.
        adr = B1 + 32'h4;
        acks = 0; bad_dat = 0; back2back = 0; prev_ack = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (rdat !== mbank[1][1]) bad_dat++;
                if (prev_ack) back2back++;
            end
            prev_ack = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("held acks", 32'(acks), 32'd5);
        chk("held back2back", 32'(back2back), 32'h0);
        chk("held dat", 32'(bad_dat), 32'h0);
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            int r;
            bit c;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            c = bit'($urandom_range(0, 1));
            case (r)
                0, 1, 2, 3: begin
                    a = (($urandom_range(0, 1) == 0) ? B0 : B1) + 32'($urandom_range(0, 7) * 4)
                        + 32'($urandom_range(0, 3));
                    op(1'b1, a, ($urandom_range(0, 3) == 0), $urandom, 4'hF, c, rand_vec(), "rnd_word");
                end
                4, 5: op(1'b1, (($urandom_range(0, 1) == 0) ? B0 : B1) + 32'h20,
                         1'b1, $urandom, 4'hF, c, rand_vec(), "rnd_rel");
                6: op(1'b1, B0 + 32'h24, 1'b0, 32'h0, 4'hF, c, rand_vec(), "rnd_stat_rd");
                7: op(1'b1, B0 + 32'h24, 1'b1, $urandom, 4'($urandom), c, rand_vec(), "rnd_stat_wr");
                8: begin
                    case ($urandom_range(0, 2))
                        0: a = B0 + 32'h28;
                        1: a = B1 + 32'h24;
                        default: a = 32'h80060000 + 32'($urandom_range(0, 255) * 4);
                    endcase
                    op(1'b1, a, bit'($urandom_range(0, 1)), $urandom, 4'hF, c, rand_vec(), "rnd_unmapped");
                end
                default: op(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, c, rand_vec(), "rnd_idle");
            endcase
        end

        // Make sure there is state to clear, then reset between strobe and ack.
        wr(B0 + 32'h20, 32'h0, "pre_rst_rel");
        cap_only(a5, "pre_rst_cap");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B0;
        #2 rst_n = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("rst_mid acks", 32'(acks), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("post_rst full", {30'h0, full_o}, 32'h0);
        chk("post_rst ovf", {31'h0, ovf_o}, 32'h0);
        rd(B0 + 32'h24, "post_rst_status");
        rd(B0, "post_rst_b0w0");
        rd(B0 + 32'h1C, "post_rst_b0w7");
        rd(B1 + 32'h8, "post_rst_b1w2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spike_output_buffer.md
Name: spike_output_buffer

Overview:
- Wishbone read-side responder for neuron output spikes: captures the 256-bit spike_neuron vector from the neuron core on a capture strobe into one of two ping-pong banks.
- The host reads each captured vector as eight 32-bit words and then releases the bank.
- Completes the data path: the host writes parameters into the neuron core and reads results back through this block at OMEM_BASE_0/OMEM_BASE_1.

Parameters:
- NUM_NEURONS, 256, spike vector width; must be a multiple of 32 (WORDS = NUM_NEURONS/32 = 8).
- OMEM_BASE_0, 32'h80040000, base address of bank 0.
- OMEM_BASE_1, 32'h80050000, base address of bank 1.
- CNT_WIDTH, 8, width of the successful-capture counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle active.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- spike_neuron_i  in  NUM_NEURONS  spike vector from the neuron core.
- spike_valid_i  in  1  single-cycle capture strobe (one per timestep).
- bank_full_o  out  2  per-bank full flags.
- overflow_o  out  1  sticky dropped-capture flag.

Behaviour:
- Reset (wb_rst_i low, asynchronous): both banks cleared to 0; full flags = 0; wr_bank = 0; overflow = 0; counter = 0; wbs_ack_o = 0; wbs_dat_o = 0. An in-flight Wishbone access is abandoned with no ack. Release is synchronous to the clock.
- Address map, relative to the bank base (byte offsets):
  - Bank k, word w (w = 0..7) at +4*w holds spike_neuron[32*w+31 : 32*w] of the captured vector, read-only. Writes are acked and ignored.
  - Bank k release at +0x20: any write clears full[k]. Reads return 0.
  - Status at OMEM_BASE_0 + 0x24, read layout: [0] full0, [1] full1, [2] wr_bank, [3] overflow, [15:8] capture count, others 0.
  - Status write: W1C on overflow when wbs_sel_i[0] = 1 and dat[3] = 1. All other bits are read-only.
  - wbs_adr_i[1:0] is ignored.
  - Any other address: no ack, and wbs_dat_o stays 0. Other slaves share the bus.
- Wishbone handshake:
  - hit = cyc & stb & address decoded & !ack.
  - ack is registered and asserts exactly 1 cycle after hit, as a single-cycle pulse.
  - Read data is registered alongside ack and returns to 0 the cycle after ack.
  - If stb is held, the next ack comes no sooner than 2 cycles after the previous one.
  - A write's side effect (release or W1C) takes effect on the ack cycle edge.
- Capture, on a spike_valid_i cycle:
  - If full[wr_bank] = 0: bank[wr_bank] <= spike_neuron_i; full[wr_bank] <= 1; wr_bank toggles; counter +1, wrapping modulo 2^CNT_WIDTH.
  - If full[wr_bank] = 1: the vector is dropped; overflow <= 1; bank contents, wr_bank and counter are unchanged.
- Simultaneous events:
  - Release of bank k and capture into bank k in the same cycle: release is applied first, so the capture succeeds with no overflow and full[k] ends at 1.
  - W1C of overflow and a dropping capture in the same cycle: overflow ends at 1 (set wins).
  - A host read of a bank in the same cycle as a capture into that bank returns the old contents.
- bank_full_o = {full1, full0} and overflow_o are direct register outputs.

Test Plan:
- Reset then read status at 0x80040024 -> ack 1 cycle after stb, data 0x00000000; bank_full_o = 00.
- Capture 0xA5A5…A5 (256b) with spike_valid_i, then read 0x80040000 and 0x8004001C -> both 0xA5A5A5A5. Status = 0x00000105 (full0, wr_bank = 1, count 1).
- Three captures with no release -> captures 1 and 2 fill banks 0 and 1; capture 3 is dropped. overflow_o = 1, count = 2, bank 0 unchanged. W1C 0x8 to status -> overflow 0.
- Full bank 0, wr_bank = 0: write 0x80040020 on the same cycle as spike_valid_i with vector 0x1 -> overflow stays 0, bank 0 word 0 = 0x00000001, full0 = 1.
- Read 0x80060000 with stb held 10 cycles -> wbs_ack_o never asserts, wbs_dat_o = 0. Read 0x80050004 with stb held -> acks at most every other cycle.
- Assert wb_rst_i low in the cycle between stb and ack -> ack never asserts; all flags, counter and bank words read 0 after reset release.
